// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state type, grant-select encoding and starve counter sizing
// shared by mem_arbiter and arb_starve_counter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  // Width needed to hold 0..limit inclusive
  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// arb_starve_counter: counts data grants that bypassed a waiting instruction
// fetch. Saturates at LIMIT and clears on any instruction grant. Only
// instantiated when MEM_ARBITER_STARVE_GUARD_EN is defined.
module arb_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic inst_grant,
  input  logic data_grant_waiting,
  output logic at_limit
);

  localparam int                   CNT_WIDTH = starve_cnt_width(LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(LIMIT);

  logic [CNT_WIDTH-1:0] cnt;

  // Saturating count of bypassing data grants; an instruction grant restarts it
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt <= '0;
    end else if (inst_grant) begin
      cnt <= '0;
    end else if (data_grant_waiting && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single memory port with one access outstanding. Data has priority; the
// optional starvation guard (macro MEM_ARBITER_STARVE_GUARD_EN) hands the
// port to a waiting instruction fetch after STARVE_LIMIT bypassing data grants.
// Every output is a register; requests are only looked at in IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inst_req,
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  output logic [DATA_WIDTH-1:0]   o_inst_rdata,
  output logic                    o_inst_ack,
  input  logic                    i_data_req,
  input  logic                    i_data_we,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_data_be,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_data_ack,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_ack
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t            state, state_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [BE_WIDTH-1:0]   mem_be_nxt;
  logic                  inst_ack_nxt, data_ack_nxt;
  logic [DATA_WIDTH-1:0] inst_rdata_nxt, data_rdata_nxt;
  logic                  starve_hit;
  logic                  gnt_sel;

  // Data wins a tie unless the guard says the fetch has waited long enough
  assign gnt_sel = (i_inst_req && (!i_data_req || starve_hit)) ? GNT_INST : GNT_DATA;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic inst_grant, data_grant_waiting;

  assign inst_grant         = (state == IDLE) && i_inst_req && (gnt_sel == GNT_INST);
  assign data_grant_waiting = (state == IDLE) && i_data_req && i_inst_req && (gnt_sel == GNT_DATA);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk_sys            (i_clk),
    .rst                (i_rst),
    .inst_grant         (inst_grant),
    .data_grant_waiting (data_grant_waiting),
    .at_limit           (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  // Next state and next values of all registered outputs
  always_comb begin
    state_nxt      = state;
    mem_req_nxt    = o_mem_req;
    mem_we_nxt     = o_mem_we;
    mem_addr_nxt   = o_mem_addr;
    mem_wdata_nxt  = o_mem_wdata;
    mem_be_nxt     = o_mem_be;
    inst_ack_nxt   = 1'b0;
    data_ack_nxt   = 1'b0;
    inst_rdata_nxt = o_inst_rdata;
    data_rdata_nxt = o_data_rdata;
    case (state)
      IDLE: begin
        if (i_inst_req || i_data_req) begin
          mem_req_nxt = 1'b1;
          if (gnt_sel == GNT_INST) begin
            state_nxt     = IBUS;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = i_inst_addr;
            mem_wdata_nxt = '0;
            mem_be_nxt    = '1;
          end else begin
            state_nxt     = DBUS;
            mem_we_nxt    = i_data_we;
            mem_addr_nxt  = i_data_addr;
            mem_wdata_nxt = i_data_wdata;
            mem_be_nxt    = i_data_be;
          end
        end
      end
      IBUS: begin
        if (i_mem_ack) begin
          state_nxt      = RESP;
          mem_req_nxt    = 1'b0;
          inst_ack_nxt   = 1'b1;
          inst_rdata_nxt = i_mem_rdata;
        end
      end
      DBUS: begin
        if (i_mem_ack) begin
          state_nxt    = RESP;
          mem_req_nxt  = 1'b0;
          data_ack_nxt = 1'b1;
          // Write completions return no data; keep the last read value
          if (!o_mem_we) begin
            data_rdata_nxt = i_mem_rdata;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_be     <= '0;
      o_inst_ack   <= 1'b0;
      o_data_ack   <= 1'b0;
      o_inst_rdata <= '0;
      o_data_rdata <= '0;
    end else begin
      state        <= state_nxt;
      o_mem_req    <= mem_req_nxt;
      o_mem_we     <= mem_we_nxt;
      o_mem_addr   <= mem_addr_nxt;
      o_mem_wdata  <= mem_wdata_nxt;
      o_mem_be     <= mem_be_nxt;
      o_inst_ack   <= inst_ack_nxt;
      o_data_ack   <= data_ack_nxt;
      o_inst_rdata <= inst_rdata_nxt;
      o_data_rdata <= data_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. A per-cycle reference model derived
// from the arbitration rules checks every output every cycle; table vectors,
// directed sequences and a randomized phase drive the stimulus.
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_inst_req;
  logic [AW-1:0] i_inst_addr;
  logic [DW-1:0] o_inst_rdata;
  logic          o_inst_ack;
  logic          i_data_req;
  logic          i_data_we;
  logic [AW-1:0] i_data_addr;
  logic [DW-1:0] i_data_wdata;
  logic [BW-1:0] i_data_be;
  logic [DW-1:0] o_data_rdata;
  logic          o_data_ack;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [BW-1:0] o_mem_be;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ack;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_inst_req   (i_inst_req),
    .i_inst_addr  (i_inst_addr),
    .o_inst_rdata (o_inst_rdata),
    .o_inst_ack   (o_inst_ack),
    .i_data_req   (i_data_req),
    .i_data_we    (i_data_we),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .i_data_be    (i_data_be),
    .o_data_rdata (o_data_rdata),
    .o_data_ack   (o_data_ack),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ack    (i_mem_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // inputs as seen by the upcoming edge
  bit            s_rst, s_ireq, s_dreq, s_dwe, s_ack;
  logic [AW-1:0] s_iaddr, s_daddr;
  logic [DW-1:0] s_dwdata, s_rdata;
  logic [BW-1:0] s_dbe;

  // reference model: who owns the memory port, and what the outputs should be
  int            m_owner = 0;   // 0 none, 1 instruction, 2 data
  bit            m_resp  = 1'b0;
  int            m_starve = 0;
  logic [AW-1:0] m_addr  = '0;
  bit            m_we    = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be    = '0;
  bit            m_iack  = 1'b0;
  bit            m_dack  = 1'b0;
  logic [DW-1:0] m_irdata = '0;
  logic [DW-1:0] m_drdata = '0;

  // memory responder
  bit            auto_mem = 1'b1;
  bit            fixed_en = 1'b1;
  bit            rand_lat = 1'b0;
  bit            spurious = 1'b0;
  int            mem_lat  = 1;
  int            mem_cnt  = 0;
  logic [DW-1:0] fixed_rdata = '0;

  int ack_log[$];   // 0 = instruction completion, 1 = data completion
  int rise_cyc[$];
  bit prev_mem_req = 1'b0;

  typedef struct {
    bit            ireq;
    bit            dreq;
    bit            we;
    logic [AW-1:0] iaddr;
    logic [AW-1:0] daddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            lat;
    logic [DW-1:0] rdata;
    bit            exp_data;
    logic [AW-1:0] exp_addr;
    bit            exp_we;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_irdata;
    logic [DW-1:0] exp_drdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    bit inst_wins;
    m_iack = 1'b0;
    m_dack = 1'b0;
    if (s_rst) begin
      m_owner = 0; m_resp = 1'b0; m_starve = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0; m_be = '0;
      m_irdata = '0; m_drdata = '0;
    end else if (m_owner != 0) begin
      if (s_ack) begin
        if (m_owner == 1) begin
          m_iack = 1'b1;
          m_irdata = s_rdata;
        end else begin
          m_dack = 1'b1;
          if (!m_we) m_drdata = s_rdata;
        end
        m_owner = 0;
        m_resp  = 1'b1;
      end
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (s_ireq || s_dreq) begin
      inst_wins = s_ireq && (!s_dreq || (GUARD && (m_starve == LIMIT)));
      if (inst_wins) begin
        m_owner = 1; m_addr = s_iaddr; m_we = 1'b0; m_be = '1;
        m_starve = 0;
      end else begin
        m_owner = 2; m_addr = s_daddr; m_we = s_dwe; m_wdata = s_dwdata; m_be = s_dbe;
        if (s_ireq && (m_starve < LIMIT)) m_starve++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_req",    64'(o_mem_req),    64'(m_owner != 0));
    chk("inst_ack",   64'(o_inst_ack),   64'(m_iack));
    chk("data_ack",   64'(o_data_ack),   64'(m_dack));
    chk("inst_rdata", 64'(o_inst_rdata), 64'(m_irdata));
    chk("data_rdata", 64'(o_data_rdata), 64'(m_drdata));
    if (m_owner != 0) begin
      chk("mem_addr", 64'(o_mem_addr), 64'(m_addr));
      chk("mem_we",   64'(o_mem_we),   64'(m_we));
      chk("mem_be",   64'(o_mem_be),   64'(m_be));
      if (m_owner == 2) chk("mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
    end
  endtask

  task automatic mem_drive();
    i_mem_ack = 1'b0;
    if (o_mem_req) begin
      if (mem_cnt == 0 && rand_lat) mem_lat = $urandom_range(1, 4);
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = fixed_en ? fixed_rdata : $urandom;
      end
    end else begin
      mem_cnt = 0;
      if (spurious && ($urandom_range(0, 3) == 0)) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = $urandom;
      end
    end
  endtask

  task automatic step();
    s_rst = i_rst; s_ireq = i_inst_req; s_iaddr = i_inst_addr;
    s_dreq = i_data_req; s_dwe = i_data_we; s_daddr = i_data_addr;
    s_dwdata = i_data_wdata; s_dbe = i_data_be;
    s_ack = i_mem_ack; s_rdata = i_mem_rdata;
    @(posedge i_clk);
    #1;
    cyc++;
    model_update();
    check_outputs();
    if (o_mem_req && !prev_mem_req) rise_cyc.push_back(cyc);
    prev_mem_req = o_mem_req;
    if (o_inst_ack) ack_log.push_back(0);
    if (o_data_ack) ack_log.push_back(1);
    if (auto_mem) mem_drive();
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_inst_req = 1'b0; i_data_req = 1'b0; i_mem_ack = 1'b0;
    step();
    i_rst = 1'b0;
  endtask

  task automatic wait_ack(input bit data_side, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (data_side ? o_data_ack : o_inst_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_within_bound", 64'(ok), 64'(1));
  endtask

  task automatic run_access(input bit data_side, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                            input logic [DW-1:0] rdata, input int lat);
    bit ok;
    fixed_en = 1'b1; fixed_rdata = rdata; mem_lat = lat;
    if (data_side) begin
      i_data_req = 1'b1; i_data_we = we; i_data_addr = addr; i_data_wdata = wdata; i_data_be = be;
    end else begin
      i_inst_req = 1'b1; i_inst_addr = addr;
    end
    wait_ack(data_side, ok);
    i_inst_req = 1'b0;
    i_data_req = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    int c0;

    i_rst = 1'b1; i_inst_req = 1'b0; i_inst_addr = '0;
    i_data_req = 1'b0; i_data_we = 1'b0; i_data_addr = '0; i_data_wdata = '0; i_data_be = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;

    vecs[0] = '{1, 0, 0, 32'h100, 32'h0, 32'h0, 4'hF, 2, 32'h00500093,
                0, 32'h100, 0, 4'hF, 32'h00500093, 32'h0};
    vecs[1] = '{0, 1, 0, 32'h0, 32'h2000, 32'h0, 4'hF, 1, 32'h11223344,
                1, 32'h2000, 0, 4'hF, 32'h0, 32'h11223344};
    vecs[2] = '{0, 1, 1, 32'h0, 32'h2004, 32'hDEADBEEF, 4'b0011, 3, 32'hA5A5A5A5,
                1, 32'h2004, 1, 4'b0011, 32'h0, 32'h0};
    vecs[3] = '{1, 1, 0, 32'h104, 32'h2000, 32'h0, 4'hF, 1, 32'h0BADF00D,
                1, 32'h2000, 0, 4'hF, 32'h0, 32'h0BADF00D};
    vecs[4] = '{1, 1, 1, 32'h108, 32'h3000, 32'h12345678, 4'b1100, 4, 32'h77777777,
                1, 32'h3000, 1, 4'b1100, 32'h0, 32'h0};
    vecs[5] = '{1, 0, 1, 32'hFFFFFFFC, 32'h4000, 32'h0, 4'b0101, 1, 32'hFFFFFFFF,
                0, 32'hFFFFFFFC, 0, 4'hF, 32'hFFFFFFFF, 32'h0};

    // table vectors: one isolated access each, from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      chk("rst_mem_addr",  64'(o_mem_addr),  64'(0));
      chk("rst_mem_we",    64'(o_mem_we),    64'(0));
      chk("rst_mem_wdata", 64'(o_mem_wdata), 64'(0));
      chk("rst_mem_be",    64'(o_mem_be),    64'(0));
      base = ack_log.size();
      fixed_en = 1'b1; rand_lat = 1'b0; fixed_rdata = vecs[v].rdata; mem_lat = vecs[v].lat;
      i_inst_req = vecs[v].ireq; i_inst_addr = vecs[v].iaddr;
      i_data_req = vecs[v].dreq; i_data_we = vecs[v].we; i_data_addr = vecs[v].daddr;
      i_data_wdata = vecs[v].wdata; i_data_be = vecs[v].be;
      step();
      chk("vec_req_latency", 64'(o_mem_req),  64'(1));
      chk("vec_addr",        64'(o_mem_addr), 64'(vecs[v].exp_addr));
      chk("vec_we",          64'(o_mem_we),   64'(vecs[v].exp_we));
      chk("vec_be",          64'(o_mem_be),   64'(vecs[v].exp_be));
      wait_ack(vecs[v].exp_data, ok);
      i_inst_req = 1'b0; i_data_req = 1'b0;
      repeat (3) step();
      chk("vec_ack_count", 64'(ack_log.size() - base), 64'(1));
      if (ack_log.size() > base) chk("vec_ack_side", 64'(ack_log[base]), 64'(vecs[v].exp_data));
      chk("vec_inst_rdata", 64'(o_inst_rdata), 64'(vecs[v].exp_irdata));
      chk("vec_data_rdata", 64'(o_data_rdata), 64'(vecs[v].exp_drdata));
    end

    // simultaneous requests: data first, instruction in the IDLE after RESP
    do_reset();
    fixed_en = 1'b1; fixed_rdata = 32'h01020304; mem_lat = 2;
    i_inst_req = 1'b1; i_inst_addr = 32'h104;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h2000; i_data_be = '1;
    wait_ack(1'b1, ok);
    c0 = cyc;
    i_data_req = 1'b0;
    step();
    chk("sim_resp_idle_req", 64'(o_mem_req), 64'(0));
    step();
    chk("sim_inst_grant_cycle", 64'(rise_cyc[$]), 64'(c0 + 2));
    chk("sim_inst_addr",        64'(o_mem_addr),  64'(32'h104));
    wait_ack(1'b0, ok);
    i_inst_req = 1'b0;
    step();

    // write leaves read data alone; spurious acks in IDLE do nothing
    do_reset();
    run_access(1'b1, 1'b0, 32'h2008, 32'h0, 4'hF, 32'h0BADF00D, 1);
    run_access(1'b0, 1'b0, 32'h10C, 32'h0, 4'h0, 32'hCAFEF00D, 2);
    base = ack_log.size();
    run_access(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 32'hA5A5A5A5, 3);
    chk("wr_ack_once",      64'(ack_log.size() - base), 64'(1));
    chk("wr_data_rdata",    64'(o_data_rdata), 64'(32'h0BADF00D));
    auto_mem = 1'b0;
    base = ack_log.size();
    repeat (4) begin
      i_mem_ack = 1'b1; i_mem_rdata = $urandom;
      step();
      chk("spur_no_inst_ack", 64'(o_inst_ack), 64'(0));
      chk("spur_no_data_ack", 64'(o_data_ack), 64'(0));
    end
    i_mem_ack = 1'b0;
    step();
    chk("spur_ack_count",  64'(ack_log.size() - base), 64'(0));
    chk("spur_inst_rdata", 64'(o_inst_rdata), 64'(32'hCAFEF00D));
    chk("spur_data_rdata", 64'(o_data_rdata), 64'(32'h0BADF00D));
    auto_mem = 1'b1;

    // starve guard: both held continuously
    do_reset();
    ack_log.delete();
    fixed_en = 1'b1; fixed_rdata = 32'h13; mem_lat = 1;
    i_inst_req = 1'b1; i_inst_addr = 32'h104;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h2000; i_data_be = '1;
    for (int k = 0; k < 200 && ack_log.size() < 10; k++) step();
    i_inst_req = 1'b0; i_data_req = 1'b0;
    step(); step();
    chk("starve_grant_count", 64'(ack_log.size() >= 10), 64'(1));
    for (int k = 0; k < 10 && k < ack_log.size(); k++) begin
      chk("starve_order", 64'(ack_log[k]), 64'((GUARD && (k % (LIMIT + 1) == LIMIT)) ? 0 : 1));
    end

    // reset in the middle of a data access, then a late ack
    do_reset();
    auto_mem = 1'b0; i_mem_ack = 1'b0;
    base = ack_log.size();
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h2000; i_data_be = '1;
    step();
    chk("rstmid_granted", 64'(o_mem_req), 64'(1));
    i_rst = 1'b1; i_data_req = 1'b0;
    step();
    chk("rstmid_req_clear", 64'(o_mem_req), 64'(0));
    i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h55AA55AA;
    step();
    chk("rstmid_late_ack", 64'(o_data_ack), 64'(0));
    i_mem_ack = 1'b0;
    step(); step();
    chk("rstmid_ack_count",  64'(ack_log.size() - base), 64'(0));
    chk("rstmid_data_rdata", 64'(o_data_rdata), 64'(0));
    i_inst_req = 1'b1; i_inst_addr = 32'h100;
    step();
    chk("rstmid_idle_grant", 64'(o_mem_req), 64'(1));
    auto_mem = 1'b1; fixed_rdata = 32'h00500093; mem_lat = 1;
    wait_ack(1'b0, ok);
    i_inst_req = 1'b0;
    step();

    // randomized traffic against the reference model
    fixed_en = 1'b0; rand_lat = 1'b1; spurious = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      i_rst        = ($urandom_range(0, 249) == 0);
      i_inst_req   = ($urandom_range(0, 3) != 0);
      i_inst_addr  = $urandom;
      i_data_req   = ($urandom_range(0, 3) != 0);
      i_data_we    = 1'($urandom_range(0, 1));
      i_data_addr  = $urandom;
      i_data_wdata = $urandom;
      i_data_be    = BW'($urandom);
      step();
    end
    i_rst = 1'b0; i_inst_req = 1'b0; i_data_req = 1'b0; spurious = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
